log_fp_pipe: RTL

- Streaming base-b logarithm for the MFCC log-energy stage. Takes IEEE-754 single-precision mel filterbank energies and produces a signed fixed-point log value for the DCT stage.
- Decomposition: log_b(x) = (e-127)*log_b(2) + log_b(1.m).
  - The mantissa term comes from an external synchronous LUT.
  - The exponent term is an integer-times-constant product.
- 3-stage pipeline with valid/ready handshake on both sides, a channel tag per sample, and classification of special inputs.

---
 rtl/log_fp_pipe.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/log_fp_pipe.sv
`default_nettype none
// ============================================================================
// Module   : log_fp_pipe
// Purpose  : Streaming base-b logarithm of IEEE-754 single-precision energies.
//            log_b(x) = (e-127)*log_b(2) + log_b(1.m). The mantissa term comes
//            from an external 1-cycle synchronous LUT. Three pipeline stages
//            advance together under one global valid/ready enable.
// Options  : LOG_FLOOR_EN - clamp results, and the zero/negative outputs,
//            to LOG_FLOOR instead of the most negative code.
// Revision : 1.0 - initial release
// ============================================================================
module log_fp_pipe #(
  parameter int                    MAN_ADDR_WIDTH = 12,
  parameter int                    FRAC_BITS      = 16,
  parameter int                    OUT_WIDTH      = 24,
  parameter logic [FRAC_BITS-1:0]  LOG_BASE_CONST = 16'h4D10,
  parameter int                    CH_WIDTH       = 5,
  parameter logic [OUT_WIDTH-1:0]  LOG_FLOOR      = 24'hF60000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_data,
  input  logic [CH_WIDTH-1:0]       in_ch,
  output logic [MAN_ADDR_WIDTH-1:0] man_addr,
  input  logic [FRAC_BITS-1:0]      man_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [OUT_WIDTH-1:0]      out_data,
  output logic [CH_WIDTH-1:0]       out_ch,
  output logic [1:0]                out_flag
);

  // Input classification codes carried alongside each sample
  localparam logic [1:0] c_FLAG_NORM = 2'b00;
  localparam logic [1:0] c_FLAG_ZERO = 2'b01;
  localparam logic [1:0] c_FLAG_NEG  = 2'b10;
  localparam logic [1:0] c_FLAG_INF  = 2'b11;

  // Product of a 9-bit signed exponent and an unsigned FRAC_BITS constant
  localparam int c_PROD_W = 9 + FRAC_BITS + 1;
  // Sum width keeps one guard bit above both the product and the output range
  localparam int c_SUM_W  = ((c_PROD_W > OUT_WIDTH) ? c_PROD_W : OUT_WIDTH) + 1;

  localparam logic signed [c_SUM_W-1:0] c_SAT_MAX =
    {{(c_SUM_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [c_SUM_W-1:0] c_SAT_MIN = ~c_SAT_MAX;
  localparam logic [OUT_WIDTH-1:0] c_OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0] c_OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  // Global pipeline enable: everything moves unless the output is blocked
  logic w_adv;

  // Stage 1 state
  logic                      v1_q;
  logic [7:0]                exp1_q;
  logic [MAN_ADDR_WIDTH-1:0] addr1_q;
  logic [CH_WIDTH-1:0]       ch1_q;
  logic [1:0]                flag1_q;

  // Stage 2 state
  logic                      v2_q;
  logic signed [c_PROD_W-1:0] prod2_q;
  logic [FRAC_BITS-1:0]      man2_q;
  logic [CH_WIDTH-1:0]       ch2_q;
  logic [1:0]                flag2_q;

  // Stage 3 (output) state
  logic                      out_valid_q;
  logic [OUT_WIDTH-1:0]      out_data_q;
  logic [OUT_WIDTH-1:0]      out_data_d;
  logic [CH_WIDTH-1:0]       out_ch_q;
  logic [1:0]                out_flag_q;

  logic [7:0]                w_in_exp;
  logic [MAN_ADDR_WIDTH-1:0] w_in_addr;
  logic [1:0]                w_in_flag;

  assign w_adv     = !out_valid_q || out_ready;
  assign in_ready  = w_adv;
  assign w_in_exp  = in_data[30:23];
  assign w_in_addr = in_data[22 -: MAN_ADDR_WIDTH];

  // Mantissa bits below the LUT index do not affect the result
  logic w_unused_in;
  assign w_unused_in = ^in_data[22-MAN_ADDR_WIDTH:0];

  // While stalled the LUT keeps reading the stage-1 address, so man_data
  // still belongs to the stage-1 sample when the pipeline resumes.
  assign man_addr = w_adv ? w_in_addr : addr1_q;

  // Classify the incoming word; inf/NaN wins over zero, zero over sign
  always_comb begin
    w_in_flag = c_FLAG_NORM;
    if (w_in_exp == 8'hFF)
      w_in_flag = c_FLAG_INF;
    else if (w_in_exp == 8'h00)
      w_in_flag = c_FLAG_ZERO;
    else if (in_data[31])
      w_in_flag = c_FLAG_NEG;
  end

  // Stage 1: capture exponent, LUT address, tag and class
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q    <= 1'b0;
      exp1_q  <= '0;
      addr1_q <= '0;
      ch1_q   <= '0;
      flag1_q <= '0;
    end else if (w_adv) begin
      v1_q    <= in_valid;
      exp1_q  <= w_in_exp;
      addr1_q <= w_in_addr;
      ch1_q   <= in_ch;
      flag1_q <= w_in_flag;
    end
  end

  // Exponent term: (e - 127) * log_b(2), signed, at FRAC_BITS scale
  logic signed [8:0]          w_exp_s;
  logic signed [c_PROD_W-1:0] w_exp_ext;
  logic signed [c_PROD_W-1:0] w_const_ext;
  logic signed [c_PROD_W-1:0] w_prod;

  assign w_exp_s     = $signed({1'b0, exp1_q}) - 9'sd127;
  assign w_exp_ext   = {{(c_PROD_W-9){w_exp_s[8]}}, w_exp_s};
  assign w_const_ext = {{(c_PROD_W-FRAC_BITS){1'b0}}, LOG_BASE_CONST};
  assign w_prod      = w_exp_ext * w_const_ext;

  // Stage 2: register the exponent product and the LUT word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_q    <= 1'b0;
      prod2_q <= '0;
      man2_q  <= '0;
      ch2_q   <= '0;
      flag2_q <= '0;
    end else if (w_adv) begin
      v2_q    <= v1_q;
      prod2_q <= w_prod;
      man2_q  <= man_data;
      ch2_q   <= ch1_q;
      flag2_q <= flag1_q;
    end
  end

  logic signed [c_SUM_W-1:0] w_sum;
  logic [OUT_WIDTH-1:0]      w_sat;
  logic [OUT_WIDTH-1:0]      w_low;

  assign w_sum = {{(c_SUM_W-c_PROD_W){prod2_q[c_PROD_W-1]}}, prod2_q}
               + {{(c_SUM_W-FRAC_BITS){1'b0}}, man2_q};

`ifdef LOG_FLOOR_EN
  // Saturate to the output range, then clamp at the floor
  always_comb begin
    w_low = LOG_FLOOR;
    if (w_sum > c_SAT_MAX)
      w_sat = c_OUT_MAX;
    else if (w_sum < c_SAT_MIN)
      w_sat = c_OUT_MIN;
    else
      w_sat = w_sum[OUT_WIDTH-1:0];
    if ($signed(w_sat) < $signed(LOG_FLOOR))
      w_sat = LOG_FLOOR;
  end
`else
  // The floor value only matters when clamping is built in
  logic w_unused_floor;
  assign w_unused_floor = ^LOG_FLOOR;

  // Saturate to the output range
  always_comb begin
    w_low = c_OUT_MIN;
    if (w_sum > c_SAT_MAX)
      w_sat = c_OUT_MAX;
    else if (w_sum < c_SAT_MIN)
      w_sat = c_OUT_MIN;
    else
      w_sat = w_sum[OUT_WIDTH-1:0];
  end
`endif

  // Special inputs override the arithmetic result
  always_comb begin
    out_data_d = w_sat;
    case (flag2_q)
      c_FLAG_ZERO, c_FLAG_NEG: out_data_d = w_low;
      c_FLAG_INF:              out_data_d = c_OUT_MAX;
      default:                 out_data_d = w_sat;
    endcase
  end

  // Stage 3: output register, held while the consumer stalls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_flag_q  <= '0;
    end else if (w_adv) begin
      out_valid_q <= v2_q;
      out_data_q  <= out_data_d;
      out_ch_q    <= ch2_q;
      out_flag_q  <= flag2_q;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_flag  = out_flag_q;

endmodule
`default_nettype wire
